fb_line_fetch_arbiter: RTL

- Shares one single-port framebuffer RAM between two requesters: the display line prefetcher and a pixel writer (drawing engine or CPU).
- Timed from the video timing generator's pix_x/pix_y counters.
- Once per scanline it runs a non-interruptible burst that copies the next displayed line into a double-banked line buffer.
- The writer gets every memory slot the burst does not use, through a valid/ready handshake.

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_fetch_trigger.sv | 39 +++
 rtl/fb_line_fetch_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer line-fetch arbiter.
package fb_pkg;
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} fb_state_t;

    localparam int FB_WORDS_PER_LINE = 32;
    localparam int FB_LINES          = 384;
    localparam int FB_V_LAST         = 403;
    localparam int FB_FETCH_X        = 512;

    function automatic int fb_addr_w(input int lines, input int wpl);
        return $clog2(lines * wpl);
    endfunction
endpackage

// File: rtl/fb_fetch_trigger.sv
// Edge-detects the prefetch column and works out which line to fetch next.
module fb_fetch_trigger
    import fb_pkg::*;
#(
    parameter int LINES   = FB_LINES,
    parameter int V_LAST  = FB_V_LAST,
    parameter int FETCH_X = FB_FETCH_X,
    parameter int LINE_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic              trig,
    output logic              trig_ok,
    output logic [LINE_W-1:0] line
);
    localparam logic [9:0]  FX = 10'(FETCH_X);
    localparam logic [9:0]  VL = 10'(V_LAST);
    localparam logic [10:0] LN = 11'(LINES);

    logic [9:0]  prev_x;
    logic [10:0] y_next;
    logic        wrap;
    logic        fits;

    always_ff @(posedge clk) begin
        if (reset) prev_x <= '0;
        else       prev_x <= pix_x;
    end

    // A counter parked on FETCH_X fires only once.
    assign trig    = (pix_x == FX) && (prev_x != FX);
    assign y_next  = {1'b0, pix_y} + 11'd1;
    assign wrap    = (pix_y == VL);
    assign fits    = (y_next < LN);
    assign trig_ok = trig && (fits || wrap);
    assign line    = wrap ? '0 : LINE_W'(y_next);
endmodule

// File: rtl/fb_line_fetch_arbiter.sv
// Single-port framebuffer arbiter: per-line display burst into a banked line
// buffer, with the pixel writer filling every slot the burst leaves free.
module fb_line_fetch_arbiter
    import fb_pkg::*;
#(
    parameter int WORDS_PER_LINE = FB_WORDS_PER_LINE,
    parameter int LINES          = FB_LINES,
    parameter int V_LAST         = FB_V_LAST,
    parameter int FETCH_X        = FB_FETCH_X,
    parameter int ADDR_W         = fb_addr_w(FB_LINES, FB_WORDS_PER_LINE),
    parameter int DATA_W         = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [9:0]                        pix_x,
    input  logic [9:0]                        pix_y,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              lb_we,
    output logic                              lb_bank,
    output logic [$clog2(WORDS_PER_LINE)-1:0] lb_addr,
    output logic [DATA_W-1:0]                 lb_wdata,
    output logic                              fetch_busy,
    output logic                              overrun
);
    localparam int LB_AW  = $clog2(WORDS_PER_LINE);
    localparam int LINE_W = ADDR_W - LB_AW;

    fb_state_t         state;
    logic [LB_AW-1:0]  count;
    logic [LB_AW-1:0]  count_nxt;
    logic [LINE_W-1:0] line;
    logic              trig;
    logic              trig_ok;
    logic [LINE_W-1:0] trig_line;

    fb_fetch_trigger #(
        .LINES  (LINES),
        .V_LAST (V_LAST),
        .FETCH_X(FETCH_X),
        .LINE_W (LINE_W)
    ) u_trig (
        .clk    (clk),
        .reset  (reset),
        .pix_x  (pix_x),
        .pix_y  (pix_y),
        .trig   (trig),
        .trig_ok(trig_ok),
        .line   (trig_line)
    );

    assign count_nxt  = count + 1'b1;
    assign wr_ready   = (state == IDLE) && !trig && !reset;
    assign fetch_busy = (state == BURST);
    assign lb_wdata   = mem_rdata;

    // count always names the read currently on the bus, so the line buffer
    // simply trails the RAM strobe by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            line      <= '0;
            overrun   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lb_we     <= 1'b0;
            lb_bank   <= 1'b0;
            lb_addr   <= '0;
        end else begin
            lb_we   <= mem_en && !mem_we;
            lb_addr <= count;
            lb_bank <= line[0];
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if (trig_ok && state == BURST) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (trig_ok) begin
                        state    <= BURST;
                        count    <= '0;
                        line     <= trig_line;
                        mem_en   <= 1'b1;
                        mem_addr <= {trig_line, {LB_AW{1'b0}}};
                    end else if (wr_valid && wr_ready) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= wr_data;
                    end
                end
                BURST: begin
                    if (&count) begin
                        state <= IDLE;
                    end else begin
                        count    <= count_nxt;
                        mem_en   <= 1'b1;
                        mem_addr <= {line, count_nxt};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
